// File: rtl/write_buffer_ctrl.sv
// Write-request buffer: holds full-burst writes, offers un-issued entries to the
// scheduler, and drains issued entries beat by beat toward the PHY.
module write_buffer_ctrl #(
  parameter int NUM_ENTRY = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 8,
  parameter int IDX_W     = $clog2(NUM_ENTRY)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W*BURST_LEN-1:0]   req_data,
  output logic                          cand_valid,
  output logic [IDX_W-1:0]              cand_idx,
  output logic [ADDR_W-1:0]             cand_addr,
  input  logic                          issue,
  input  logic [IDX_W-1:0]              issue_idx,
  output logic                          wdata_valid,
  input  logic                          wdata_ready,
  output logic [DATA_W-1:0]             wdata,
  output logic                          wdata_last,
  output logic [IDX_W-1:0]              wdata_idx,
  output logic [IDX_W:0]                count,
  output logic                          full,
  output logic                          empty
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDX_W:0]    CNT_FULL  = (IDX_W+1)'(NUM_ENTRY);
  localparam logic [IDX_W:0]    CNT_ONE   = (IDX_W+1)'(1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_reg;
  logic [NUM_ENTRY-1:0]   valid_reg;
  logic [NUM_ENTRY-1:0]   issued_reg;
  logic [IDX_W-1:0]       sel_reg;
  logic [BEAT_W-1:0]      beat_reg;
  logic [IDX_W:0]         count_reg;
  logic [ADDR_W-1:0]      addr_mem [NUM_ENTRY];
  logic [DATA_W-1:0]      data_mem [NUM_ENTRY][BURST_LEN];
  logic [DATA_W-1:0]      req_beats [BURST_LEN];

  logic [NUM_ENTRY-1:0]   cand_vec;
  logic [NUM_ENTRY-1:0]   ready_vec;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       cand_sel;
  logic [IDX_W-1:0]       ready_idx;
  logic                   accept;
  logic                   issue_ok;
  logic                   last_hs;

  genvar gi;
  generate
    for (gi = 0; gi < BURST_LEN; gi++) begin : g_beat
      assign req_beats[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign cand_vec  = valid_reg & ~issued_reg;
  assign ready_vec = valid_reg & issued_reg;

  // Descending scans so the lowest matching index is the last one written.
  always_comb begin
    free_idx  = '0;
    cand_sel  = '0;
    ready_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_idx  = IDX_W'(i);
      if (cand_vec[i])   cand_sel  = IDX_W'(i);
      if (ready_vec[i])  ready_idx = IDX_W'(i);
    end
  end

  assign full      = (count_reg == CNT_FULL);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign req_ready = !rst && !full;
  assign accept    = req_valid && req_ready;
  assign issue_ok  = issue && valid_reg[issue_idx] && !issued_reg[issue_idx];
  assign last_hs   = (state_reg == BURST) && wdata_ready && (beat_reg == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      valid_reg  <= '0;
      issued_reg <= '0;
      sel_reg    <= '0;
      beat_reg   <= '0;
      count_reg  <= '0;
    end else begin
      // Allocation, issue and free always touch distinct entries in one cycle.
      if (accept) begin
        valid_reg[free_idx]  <= 1'b1;
        issued_reg[free_idx] <= 1'b0;
      end
      if (issue_ok) issued_reg[issue_idx] <= 1'b1;
      if (last_hs) begin
        valid_reg[sel_reg]  <= 1'b0;
        issued_reg[sel_reg] <= 1'b0;
      end

      case ({accept, last_hs})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        IDLE: begin
          if (|ready_vec) begin
            sel_reg   <= ready_idx;
            beat_reg  <= '0;
            state_reg <= BURST;
          end
        end
        BURST: begin
          if (wdata_ready) begin
            if (beat_reg == LAST_BEAT) begin
              beat_reg  <= '0;
              state_reg <= IDLE;
            end else begin
              beat_reg <= beat_reg + BEAT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_mem[free_idx] <= req_addr;
      for (int k = 0; k < BURST_LEN; k++) begin
        data_mem[free_idx][k] <= req_beats[k];
      end
    end
  end

  assign cand_valid  = |cand_vec;
  assign cand_idx    = cand_sel;
  assign cand_addr   = cand_valid ? addr_mem[cand_sel] : '0;
  assign wdata_valid = (state_reg == BURST);
  assign wdata       = wdata_valid ? data_mem[sel_reg][beat_reg] : '0;
  assign wdata_last  = wdata_valid && (beat_reg == LAST_BEAT);
  assign wdata_idx   = sel_reg;

endmodule

// File: tb/tb_write_buffer_ctrl.sv
// Randomized bench for write_buffer_ctrl against an entry-table reference model,
// preceded by short directed sequences for latency, full, ordering and reset abort.
module tb_write_buffer_ctrl;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int L  = 8;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [AW-1:0]   req_addr = '0;
  logic [DW*L-1:0] req_data = '0;
  logic            cand_valid;
  logic [IW-1:0]   cand_idx;
  logic [AW-1:0]   cand_addr;
  logic            issue = 1'b0;
  logic [IW-1:0]   issue_idx = '0;
  logic            wdata_valid;
  logic            wdata_ready = 1'b0;
  logic [DW-1:0]   wdata;
  logic            wdata_last;
  logic [IW-1:0]   wdata_idx;
  logic [IW:0]     count;
  logic            full;
  logic            empty;

  int checks   = 0;
  int failures = 0;

  write_buffer_ctrl #(.NUM_ENTRY(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .cand_valid(cand_valid), .cand_idx(cand_idx), .cand_addr(cand_addr),
    .issue(issue), .issue_idx(issue_idx),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .wdata_last(wdata_last), .wdata_idx(wdata_idx),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: a table of entries plus the burst currently on the wire.
  bit          m_valid [N];
  bit          m_issued[N];
  logic [AW-1:0] m_addr[N];
  logic [DW-1:0] m_data[N][L];
  bit          m_busy;
  int          m_sel;
  int          m_beat;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int occupied();
    int n = 0;
    for (int i = 0; i < N; i++) n += m_valid[i];
    return n;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int first_cand();
    for (int i = 0; i < N; i++) if (m_valid[i] && !m_issued[i]) return i;
    return -1;
  endfunction

  function automatic int first_issued();
    for (int i = 0; i < N; i++) if (m_valid[i] && m_issued[i]) return i;
    return -1;
  endfunction

  function automatic logic [DW*L-1:0] seq_data(input int base);
    logic [DW*L-1:0] d = '0;
    for (int k = 0; k < L; k++) d[k*DW +: DW] = DW'(base + k);
    return d;
  endfunction

  function automatic logic [DW*L-1:0] rand_data();
    logic [DW*L-1:0] d;
    for (int k = 0; k < L*DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic compare();
    int cnt = occupied();
    int c   = first_cand();
    check("req_ready", req_ready, (!rst && cnt != N));
    check("count", count, cnt);
    check("full", full, cnt == N);
    check("empty", empty, cnt == 0);
    check("cand_valid", cand_valid, c >= 0);
    if (c >= 0) begin
      check("cand_idx", cand_idx, c);
      check("cand_addr", cand_addr, m_addr[c]);
    end
    check("wdata_valid", wdata_valid, m_busy);
    if (m_busy) begin
      check("wdata", wdata, m_data[m_sel][m_beat]);
      check("wdata_last", wdata_last, m_beat == L - 1);
      check("wdata_idx", wdata_idx, m_sel);
    end
  endtask

  task automatic step_model();
    int  fr, nx;
    bit  acc, iss_ok, done;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i]  = 0;
        m_issued[i] = 0;
      end
      m_busy = 0;
      m_beat = 0;
      return;
    end
    acc    = req_valid && (occupied() != N);
    fr     = first_free();
    iss_ok = issue && m_valid[issue_idx] && !m_issued[issue_idx];
    done   = m_busy && wdata_ready && (m_beat == L - 1);
    nx     = first_issued();
    if (!m_busy) begin
      if (nx >= 0) begin
        m_busy = 1;
        m_sel  = nx;
        m_beat = 0;
      end
    end else if (wdata_ready) begin
      if (done) begin
        m_valid[m_sel]  = 0;
        m_issued[m_sel] = 0;
        m_busy = 0;
        $display("burst done idx=%0d", m_sel);
      end else begin
        m_beat++;
      end
    end
    if (acc) begin
      m_valid[fr]  = 1;
      m_issued[fr] = 0;
      m_addr[fr]   = req_addr;
      for (int k = 0; k < L; k++) m_data[fr][k] = req_data[k*DW +: DW];
      $display("accept idx=%0d addr=%0h", fr, req_addr);
    end
    if (iss_ok) m_issued[issue_idx] = 1;
  endtask

  task automatic cycle(input bit r, input bit rv, input logic [AW-1:0] a,
                       input logic [DW*L-1:0] d, input bit iss, input int iidx, input bit wr);
    @(negedge clk);
    rst         = r;
    req_valid   = rv;
    req_addr    = a;
    req_data    = d;
    issue       = iss;
    issue_idx   = IW'(iidx);
    wdata_ready = wr;
    #1 compare();
    @(posedge clk);
    step_model();
  endtask

  task automatic idle(input int n, input bit wr);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, wr);
  endtask

  task automatic do_reset();
    cycle(1, 0, '0, '0, 0, 0, 0);
    cycle(1, 0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    m_busy = 0;
    m_beat = 0;
    m_sel  = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i]  = 0;
      m_issued[i] = 0;
    end

    // Single request, issue latency and full burst drain
    do_reset();
    idle(1, 0);
    #2;
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_wvalid", wdata_valid, 0);
    cycle(0, 1, 32'h100, seq_data('h10), 0, 0, 0);
    #2;
    check("t1_cand_valid", cand_valid, 1);
    check("t1_cand_idx", cand_idx, 0);
    cycle(0, 0, '0, '0, 1, 0, 1);
    #2 check("t1_lat_t1", wdata_valid, 0);
    idle(1, 1);
    #2;
    check("t1_lat_t2", wdata_valid, 1);
    check("t1_beat0", wdata, 64'h10);
    idle(L, 1);
    #2 check("t1_count_end", count, 0);

    // Fill, hold a ninth request until a slot frees
    for (int i = 0; i < N; i++) cycle(0, 1, AW'(32'h200 + i * 64), seq_data(i * 16), 0, 0, 0);
    #2;
    check("t2_full", full, 1);
    check("t2_ready", req_ready, 0);
    cycle(0, 1, 32'h900, seq_data('h90), 1, 5, 1);
    for (int i = 0; i < 12; i++) cycle(0, 1, 32'h900, seq_data('h90), 0, 0, 1);
    #2 check("t2_full_again", full, 1);

    // LSB priority: issue 3 then 1 while idx0 is stalled
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 1, AW'(32'h300 + i), seq_data('h40 + i * 8), 0, 0, 0);
    cycle(0, 0, '0, '0, 1, 0, 0);
    cycle(0, 0, '0, '0, 1, 3, 0);
    cycle(0, 0, '0, '0, 1, 1, 0);
    idle(30, 1);

    // Stall pattern 1,0,0,1 mid-burst
    do_reset();
    cycle(0, 1, 32'h400, rand_data(), 0, 0, 0);
    cycle(0, 0, '0, '0, 1, 0, 1);
    for (int i = 0; i < 32; i++) cycle(0, 0, '0, '0, 0, 0, (i % 4 == 0) || (i % 4 == 3));

    // Ignored issues, then reset at beat 3
    do_reset();
    cycle(0, 1, 32'h500, seq_data('h50), 1, 6, 0);
    cycle(0, 0, '0, '0, 1, 0, 0);
    cycle(0, 0, '0, '0, 1, 0, 1);
    idle(3, 1);
    #2 check("t6_beat3", wdata, 64'h53);
    cycle(1, 0, '0, '0, 0, 0, 1);
    #2;
    check("t6_abort_wvalid", wdata_valid, 0);
    check("t6_abort_count", count, 0);
    check("t6_abort_empty", empty, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), $urandom, rand_data(),
            ($urandom_range(0, 9) < 4), $urandom_range(0, N - 1), ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
